// File: rtl/time_set_controller_if.sv
// rtl/time_set_controller_if.sv - button inputs and clock-control outputs of the watch front end
interface time_set_controller_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       clock_enable;
    logic [1:0] mode;
    logic       min_inc;
    logic       min_dec;
    logic       hour_inc;
    logic       hour_dec;

    modport master (
        output btn_mode, btn_up, btn_down,
        input  clock_enable, mode, min_inc, min_dec, hour_inc, hour_dec
    );

    modport slave (
        input  btn_mode, btn_up, btn_down,
        output clock_enable, mode, min_inc, min_dec, hour_inc, hour_dec
    );
endinterface

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - RUN/SET_MIN/SET_HOUR mode FSM turning raw buttons into
// Digital_Clock enable and single-cycle adjust pulses, with hold-to-repeat and idle timeout
module time_set_controller #(
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 3,
    parameter int TIMEOUT      = 30
) (
    input  logic                 Clk_1sec,
    input  logic                 reset,
    time_set_controller_if.slave bus
);
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_MIN  = 2'b01;
    localparam logic [1:0] ST_SET_HOUR = 2'b10;

    localparam int HW = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(REPEAT_DELAY);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    localparam int B_MODE = 2;
    localparam int B_UP   = 1;
    localparam int B_DN   = 0;

    // pulse vector order: {min_inc, min_dec, hour_inc, hour_dec}
    localparam logic [3:0] P_MIN_INC  = 4'b1000;
    localparam logic [3:0] P_MIN_DEC  = 4'b0100;
    localparam logic [3:0] P_HOUR_INC = 4'b0010;
    localparam logic [3:0] P_HOUR_DEC = 4'b0001;

    logic [2:0][SYNC_STAGES-1:0] r_sync;
    logic [2:0]                  r_prev;
    logic [1:0]                  r_mode;
    logic                        r_clock_enable;
    logic [3:0]                  r_pulse;
    logic [HW-1:0]               r_hold_up;
    logic [HW-1:0]               r_hold_dn;
    logic [IW-1:0]               r_idle;

    logic [2:0]    w_raw;
    logic [2:0]    w_lvl;
    logic [2:0]    w_rise;
    logic [1:0]    w_mode_nxt;
    logic [3:0]    w_pulse_nxt;
    logic [HW-1:0] w_hold_up_nxt;
    logic [HW-1:0] w_hold_dn_nxt;
    logic [IW-1:0] w_idle_nxt;
    logic          w_fire_up;
    logic          w_fire_dn;
    logic          w_in_set;

    assign w_raw    = {bus.btn_mode, bus.btn_up, bus.btn_down};
    assign w_in_set = (r_mode == ST_SET_MIN) || (r_mode == ST_SET_HOUR);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_lvl[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    assign w_rise = w_lvl & ~r_prev;

    always_comb begin
        w_mode_nxt    = r_mode;
        w_pulse_nxt   = 4'b0000;
        w_hold_up_nxt = '0;
        w_hold_dn_nxt = '0;
        w_idle_nxt    = '0;
        w_fire_up     = 1'b0;
        w_fire_dn     = 1'b0;

        if (w_rise[B_MODE]) begin
            // a mode press swallows any concurrent up/down activity
            case (r_mode)
                ST_RUN:     w_mode_nxt = ST_SET_MIN;
                ST_SET_MIN: w_mode_nxt = ST_SET_HOUR;
                default:    w_mode_nxt = ST_RUN;
            endcase
        end else if (w_in_set) begin
            if (!(w_lvl[B_UP] && w_lvl[B_DN])) begin
                if (w_lvl[B_UP]) begin
                    w_fire_up     = w_rise[B_UP] || (r_hold_up == HOLD_MAX);
                    w_hold_up_nxt = (r_hold_up == HOLD_MAX) ? r_hold_up : r_hold_up + HW'(1);
                end
                if (w_lvl[B_DN]) begin
                    w_fire_dn     = w_rise[B_DN] || (r_hold_dn == HOLD_MAX);
                    w_hold_dn_nxt = (r_hold_dn == HOLD_MAX) ? r_hold_dn : r_hold_dn + HW'(1);
                end
            end

            if (w_fire_up) begin
                w_pulse_nxt = (r_mode == ST_SET_MIN) ? P_MIN_INC : P_HOUR_INC;
            end else if (w_fire_dn) begin
                w_pulse_nxt = (r_mode == ST_SET_MIN) ? P_MIN_DEC : P_HOUR_DEC;
            end

            if (|w_lvl) begin
                w_idle_nxt = '0;
            end else if (r_idle == IDLE_LAST) begin
                w_mode_nxt = ST_RUN;
                w_idle_nxt = '0;
            end else begin
                w_idle_nxt = r_idle + IW'(1);
            end
        end else begin
            // RUN stays RUN; the unused 11 encoding falls back here as well
            w_mode_nxt = ST_RUN;
        end
    end

    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            r_sync         <= '0;
            r_prev         <= '0;
            r_mode         <= ST_RUN;
            r_clock_enable <= 1'b1;
            r_pulse        <= 4'b0000;
            r_hold_up      <= '0;
            r_hold_dn      <= '0;
            r_idle         <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
            end
            r_prev         <= w_lvl;
            r_mode         <= w_mode_nxt;
            r_clock_enable <= (w_mode_nxt == ST_RUN);
            r_pulse        <= w_pulse_nxt;
            r_hold_up      <= w_hold_up_nxt;
            r_hold_dn      <= w_hold_dn_nxt;
            r_idle         <= w_idle_nxt;
        end
    end

    assign bus.mode         = r_mode;
    assign bus.clock_enable = r_clock_enable;
    assign bus.min_inc      = r_pulse[3];
    assign bus.min_dec      = r_pulse[2];
    assign bus.hour_inc     = r_pulse[1];
    assign bus.hour_dec     = r_pulse[0];
endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - directed bench for time_set_controller with a two-deep expectation queue
module tb_time_set_controller;
    localparam logic [3:0] NONE     = 4'b0000;
    localparam logic [3:0] MIN_INC  = 4'b1000;
    localparam logic [3:0] MIN_DEC  = 4'b0100;
    localparam logic [3:0] HOUR_INC = 4'b0010;
    localparam logic [3:0] HOUR_DEC = 4'b0001;
    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] SMIN  = 2'b01;
    localparam logic [1:0] SHOUR = 2'b10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;
    logic [6:0] exp_q[$];

    time_set_controller_if bus();

    time_set_controller #(
        .SYNC_STAGES (2),
        .REPEAT_DELAY(3),
        .TIMEOUT     (30)
    ) dut (
        .Clk_1sec(clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d: observed=%b expected=%b", tag, step, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag, input logic [6:0] e);
        check({tag, ".mode"}, {2'b00, bus.mode}, {2'b00, e[6:5]});
        check({tag, ".clock_enable"}, {3'b000, bus.clock_enable}, {3'b000, e[4]});
        check({tag, ".pulses"}, {bus.min_inc, bus.min_dec, bus.hour_inc, bus.hour_dec}, e[3:0]);
    endtask

    // em/ep are the outputs this input must produce two edges later
    task automatic drive(input string tag, input logic m, input logic u, input logic d,
                         input logic [1:0] em, input logic [3:0] ep);
        logic [6:0] e;
        exp_q.push_back({em, (em == RUN), ep});
        @(negedge clk);
        bus.btn_mode = m;
        bus.btn_up   = u;
        bus.btn_down = d;
        @(posedge clk);
        #1;
        step++;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: expectation queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            compare_out(tag, e);
        end
    endtask

    task automatic idle(input string tag, input int n, input logic [1:0] em);
        for (int i = 0; i < n; i++) drive(tag, 1'b0, 1'b0, 1'b0, em, NONE);
    endtask

    task automatic apply_reset(input int n, input logic hold_up);
        @(negedge clk);
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_up   = hold_up;
        bus.btn_down = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            step++;
            compare_out("reset", {RUN, 1'b1, NONE});
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (2) exp_q.push_back({RUN, 1'b1, NONE});
    endtask

    initial begin
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;

        apply_reset(3, 1'b0);
        idle("idle_run", 10, RUN);

        drive("mode1", 1'b1, 1'b0, 1'b0, SMIN, NONE);
        idle("gap1", 5, SMIN);
        drive("mode2", 1'b1, 1'b0, 1'b0, SHOUR, NONE);
        idle("gap2", 5, SHOUR);
        drive("mode3", 1'b1, 1'b0, 1'b0, RUN, NONE);
        idle("gap3", 5, RUN);

        drive("run_up", 1'b0, 1'b1, 1'b0, RUN, NONE);
        idle("run_gap", 3, RUN);
        drive("run_dn", 1'b0, 1'b0, 1'b1, RUN, NONE);
        idle("run_gap", 3, RUN);

        drive("to_min", 1'b1, 1'b0, 1'b0, SMIN, NONE);
        idle("min_gap", 3, SMIN);
        drive("min_up1", 1'b0, 1'b1, 1'b0, SMIN, MIN_INC);
        idle("min_gap", 3, SMIN);
        drive("min_dn1", 1'b0, 1'b0, 1'b1, SMIN, MIN_DEC);
        idle("min_gap", 3, SMIN);
        for (int i = 0; i < 8; i++)
            drive("min_hold8", 1'b0, 1'b1, 1'b0, SMIN, (i == 0 || i >= 3) ? MIN_INC : NONE);
        idle("min_rel", 3, SMIN);

        drive("mode_and_up", 1'b1, 1'b1, 1'b0, SHOUR, NONE);
        idle("hour_gap", 3, SHOUR);
        drive("hour_dn1", 1'b0, 1'b0, 1'b1, SHOUR, HOUR_DEC);
        idle("hour_gap", 3, SHOUR);
        drive("up_and_dn", 1'b0, 1'b1, 1'b1, SHOUR, NONE);
        drive("up_and_dn", 1'b0, 1'b1, 1'b1, SHOUR, NONE);
        idle("hour_gap", 3, SHOUR);
        drive("hour_up1", 1'b0, 1'b1, 1'b0, SHOUR, HOUR_INC);
        idle("hour_gap", 3, SHOUR);
        drive("back_run", 1'b1, 1'b0, 1'b0, RUN, NONE);
        idle("run_gap", 3, RUN);

        drive("to_min_idle", 1'b1, 1'b0, 1'b0, SMIN, NONE);
        idle("timeout_wait", 29, SMIN);
        drive("timeout_edge", 1'b0, 1'b0, 1'b0, RUN, NONE);
        idle("after_timeout", 3, RUN);

        drive("to_min_burst", 1'b1, 1'b0, 1'b0, SMIN, NONE);
        idle("burst_gap", 2, SMIN);
        for (int i = 0; i < 6; i++)
            drive("burst", 1'b0, 1'b1, 1'b0, SMIN, (i == 0 || i >= 3) ? MIN_INC : NONE);
        apply_reset(1, 1'b1);
        for (int i = 0; i < 4; i++) drive("post_rst_held", 1'b0, 1'b1, 1'b0, RUN, NONE);
        idle("post_rst_rel", 3, RUN);
        drive("post_rst_mode", 1'b1, 1'b0, 1'b0, SMIN, NONE);
        idle("post_rst_gap", 3, SMIN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
